lcd_framebuffer: RTL and testbench

- 128x64 monochrome shadow framebuffer sitting directly upstream of the LCD12864 GDRAM streaming controller.
- Accepts pixel-level draw commands (set, clear, toggle, fill) on a valid/ready port and applies them via an internal read-modify-write pipeline.
- Exposes an independent byte read port that the controller uses to fetch GDRAM bytes in its native order: 16 bytes per row, 64 rows, MSB = leftmost pixel.

---
 rtl/lcd_framebuffer.sv | 169 ++++++++++++++++
 tb/tb_lcd_framebuffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_framebuffer.sv
// Purpose : 128x64 mono shadow framebuffer; pixel set/clear/toggle/fill via RMW, plus controller byte read port.
// Latency : pixel op done 2 cycles after accept, fill done 2^ADDR_W cycles after accept; rd_data 1 cycle after rd_addr.
// Backpr. : cmd_ready only in IDLE, so one command in flight at a time; the read port never stalls.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   cmd_valid/cmd_ready       draw command handshake
//   cmd_op                    00 set, 01 clear, 10 toggle, 11 fill
//   cmd_x, cmd_y              pixel coordinate (ignored for fill)
//   cmd_pattern               fill byte (ignored for pixel ops)
//   busy, done                command in progress / one-cycle completion pulse
//   rd_addr, rd_data          controller byte read, GDRAM order, MSB = leftmost pixel
module lcd_framebuffer #(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 64,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [6:0]        cmd_x,
   input  logic [5:0]        cmd_y,
   input  logic [7:0]        cmd_pattern,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   localparam int BPR = WIDTH / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_FILL = 2'd3;

   localparam logic [1:0] OP_SET   = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b11;

   // Extra counter bit keeps the terminal compare unambiguous: no silent wrap.
   localparam logic [ADDR_W:0] FILL_LAST = {1'b0, {ADDR_W{1'b1}}};

   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   logic [1:0]        state;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        mask_q;
   logic              oor_q;
   logic [7:0]        pat_q;
   logic [ADDR_W:0]   fill_cnt;

   logic              accept;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_oor;
   logic [7:0]        cmd_mask;

   logic [ADDR_W-1:0] porta_addr;
   logic [7:0]        porta_q;
   logic              wr_en;
   logic [7:0]        wr_data;
   logic [7:0]        rmw_byte;
   logic              fill_last;

   assign cmd_ready = (state == S_IDLE) && !rst;
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign fill_last = (fill_cnt == FILL_LAST);

   // done is gated by rst so an interrupted command never reports completion.
   assign done = !rst && ((state == S_WR) || ((state == S_FILL) && fill_last));

   assign cmd_addr = ADDR_W'(32'(cmd_y) * 32'(BPR) + 32'(cmd_x >> 3));
   assign cmd_oor  = (32'(cmd_x) >= 32'(WIDTH)) || (32'(cmd_y) >= 32'(HEIGHT));
   assign cmd_mask = 8'h80 >> cmd_x[2:0];

   always_comb begin
      rmw_byte = porta_q ^ mask_q;
      case (op_q)
         OP_SET:   rmw_byte = porta_q | mask_q;
         OP_CLEAR: rmw_byte = porta_q & ~mask_q;
         default:  rmw_byte = porta_q ^ mask_q;
      endcase
   end

   // Engine port: read in RD, write in WR or FILL. Writes are suppressed
   // during rst so the interrupted cycle leaves RAM untouched.
   always_comb begin
      porta_addr = addr_q;
      wr_en      = 1'b0;
      wr_data    = rmw_byte;
      if (state == S_FILL) begin
         porta_addr = fill_cnt[ADDR_W-1:0];
         wr_data    = pat_q;
      end
      if (!rst) begin
         if (state == S_WR && !oor_q) begin
            wr_en = 1'b1;
         end else if (state == S_FILL) begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[porta_addr] <= wr_data;
      end
      porta_q <= mem[porta_addr];
   end

   // Controller port: read-before-write on a same-address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 8'h00;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= 2'b00;
         addr_q   <= '0;
         mask_q   <= 8'h00;
         oor_q    <= 1'b0;
         pat_q    <= 8'h00;
         fill_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (cmd_op == OP_FILL) begin
                     state    <= S_FILL;
                     fill_cnt <= '0;
                     pat_q    <= cmd_pattern;
                  end else begin
                     state  <= S_RD;
                     op_q   <= cmd_op;
                     addr_q <= cmd_addr;
                     mask_q <= cmd_mask;
                     oor_q  <= cmd_oor;
                  end
               end
            end
            S_RD: begin
               state <= S_WR;
            end
            S_WR: begin
               state <= S_IDLE;
            end
            S_FILL: begin
               if (fill_last) begin
                  state <= S_IDLE;
               end
               fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_framebuffer.sv
module tb_lcd_framebuffer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [6:0] cmd_x = 7'd0;
   logic [5:0] cmd_y = 6'd0;
   logic [7:0] cmd_pattern = 8'h00;
   logic       busy;
   logic       done;
   logic [9:0] rd_addr = 10'd0;
   logic [7:0] rd_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] ref_mem [0:1023];

   always #5 clk = ~clk;

   lcd_framebuffer #(.WIDTH(128), .HEIGHT(64), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_pattern(cmd_pattern),
      .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference model: plain pixel arithmetic on a byte array.
   function automatic void model_apply(input int op, input int x, input int y, input logic [7:0] pat);
      int a;
      logic [7:0] m;
      if (op == 3) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = pat;
      end else begin
         a = y * 16 + x / 8;
         m = 8'(1 << (7 - (x % 8)));
         if (op == 0)      ref_mem[a] = ref_mem[a] | m;
         else if (op == 1) ref_mem[a] = ref_mem[a] & ~m;
         else              ref_mem[a] = ref_mem[a] ^ m;
      end
   endfunction

   task automatic do_op(input int op, input int x, input int y, input logic [7:0] pat, input string tag);
      int acc;
      int lat;
      int exp_lat;
      bit busy_bad;
      exp_lat = (op == 3) ? 1024 : 2;
      cmd_op = 2'(op); cmd_x = 7'(x); cmd_y = 6'(y); cmd_pattern = pat;
      cmd_valid = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_idle got=%b exp=1", tag, cmd_ready);
      end
      acc = cyc;
      tick;
      cmd_valid = 1'b0;
      // Scramble fields after accept: the DUT must have captured them.
      cmd_op = 2'($urandom); cmd_x = 7'($urandom); cmd_y = 6'($urandom); cmd_pattern = 8'($urandom);
      busy_bad = 1'b0;
      while (done !== 1'b1 && cyc - acc < 1100) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         tick;
      end
      lat = cyc - acc;
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL %s_done_latency got=%0d exp=%0d", tag, lat, exp_lat);
      end
      checks++;
      if (busy_bad || busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy_during_op got_low=1 exp_low=0", tag);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_ready_with_done got=%b exp=0", tag, cmd_ready);
      end
      model_apply(op, x, y, pat);
      tick;
      checks++;
      if ({done, cmd_ready, busy} !== 3'b010) begin
         failures++;
         $display("FAIL %s_after_done got(done,ready,busy)=%b exp=010", tag, {done, cmd_ready, busy});
      end
   endtask

   task automatic read_check(input int a, input logic [7:0] exp, input string tag);
      rd_addr = 10'(a);
      tick;
      checks++;
      if (rd_data !== exp) begin
         failures++;
         $display("FAIL %s addr=%0d got=%h exp=%h", tag, a, rd_data, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int bad = 0;
      int first = -1;
      logic [7:0] fgot = 8'h00;
      for (int a = 0; a < 1024; a++) begin
         rd_addr = 10'(a);
         tick;
         if (rd_data !== ref_mem[a]) begin
            bad++;
            if (first < 0) begin
               first = a;
               fgot = rd_data;
            end
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s bad_bytes=%0d first_addr=%0d got=%h exp=%h", tag, bad, first, fgot, ref_mem[first]);
      end
   endtask

   task automatic test_reset;
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick;
      tick;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_in_rst got=%b exp=0", cmd_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL reset_outputs got(ready,busy,done)=%b exp=100", {cmd_ready, busy, done});
      end
      checks++;
      if (rd_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rd_data got=%h exp=00", rd_data);
      end
   endtask

   task automatic test_fill;
      do_op(3, 0, 0, 8'hAA, "fill_aa");
      check_all("fill_aa_readback");
   endtask

   task automatic test_set_corners;
      do_op(3, 0, 0, 8'h00, "fill_00");
      do_op(0, 0, 0, 8'h00, "set_0_0");
      read_check(0, 8'h80, "set_0_0_byte");
      do_op(0, 127, 63, 8'h00, "set_127_63");
      read_check(1023, 8'h01, "set_127_63_byte");
   endtask

   task automatic test_clear_toggle;
      do_op(3, 0, 0, 8'hFF, "fill_ff");
      do_op(1, 9, 1, 8'h00, "clear_9_1");
      read_check(17, 8'hBF, "clear_byte");
      do_op(2, 9, 1, 8'h00, "toggle1");
      do_op(2, 9, 1, 8'h00, "toggle2");
      read_check(17, 8'hBF, "toggle_twice_byte");
      do_op(2, 9, 1, 8'h00, "toggle3");
      read_check(17, 8'hFF, "toggle_thrice_byte");
   endtask

   task automatic test_back_to_back;
      logic [8:0] rdy_seq;
      int idx;
      bit acc_now;
      do_op(3, 0, 0, 8'h00, "b2b_fill");
      idx = 0;
      cmd_op = 2'b00; cmd_x = 7'd40; cmd_y = 6'd0;
      cmd_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         rdy_seq[8-c] = cmd_ready;
         acc_now = cmd_valid && cmd_ready;
         tick;
         if (acc_now) begin
            idx++;
            if (idx == 3) cmd_valid = 1'b0;
            else          cmd_x = 7'(40 + idx);
         end
      end
      cmd_valid = 1'b0;
      tick;
      for (int i = 0; i < 3; i++) model_apply(0, 40 + i, 0, 8'h00);
      checks++;
      if (rdy_seq !== 9'b100100100) begin
         failures++;
         $display("FAIL b2b_ready_pattern got=%b exp=100100100", rdy_seq);
      end
      checks++;
      if (idx != 3) begin
         failures++;
         $display("FAIL b2b_accept_count got=%0d exp=3", idx);
      end
      read_check(5, 8'hE0, "b2b_byte5");
   endtask

   task automatic test_collision;
      int acc;
      rd_addr = 10'd33;
      cmd_op = 2'b00; cmd_x = 7'd11; cmd_y = 6'd2;
      cmd_valid = 1'b1;
      acc = cyc;
      tick;
      cmd_valid = 1'b0;
      while (done !== 1'b1 && cyc - acc < 50) tick;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL collision_done_timeout got=0 exp=1");
      end
      tick;
      checks++;
      if (rd_data !== 8'h00) begin
         failures++;
         $display("FAIL collision_old_byte got=%h exp=00", rd_data);
      end
      tick;
      checks++;
      if (rd_data !== 8'h10) begin
         failures++;
         $display("FAIL collision_new_byte got=%h exp=10", rd_data);
      end
      model_apply(0, 11, 2, 8'h00);
   endtask

   task automatic test_random;
      do_op(3, 0, 0, 8'($urandom), "rnd_fill");
      for (int i = 0; i < 150; i++) begin
         do_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 63)), 8'h00, "rnd_op");
      end
      check_all("rnd_readback");
   endtask

   task automatic test_reset_midfill;
      int acc;
      int p;
      int bad;
      bit saw_done;
      do_op(3, 0, 0, 8'h00, "mid_prefill");
      cmd_op = 2'b11; cmd_pattern = 8'h55; cmd_valid = 1'b1;
      acc = cyc;
      tick;
      cmd_valid = 1'b0;
      saw_done = 1'b0;
      while (cyc - acc < 301) begin
         if (done === 1'b1) saw_done = 1'b1;
         tick;
      end
      rst = 1'b1;
      #1;
      if (done === 1'b1) saw_done = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_idle got(busy,done)=%b%b exp=00", busy, done);
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL midrst_no_done got=1 exp=0");
      end
      p = 0;
      bad = 0;
      for (int a = 0; a < 1024; a++) begin
         rd_addr = 10'(a);
         tick;
         if (a == p && rd_data === 8'h55) p++;
         else if (rd_data !== 8'h00) bad++;
      end
      checks++;
      if (p < 299 || p > 301) begin
         failures++;
         $display("FAIL midrst_prefix got=%0d exp=300(+-1)", p);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midrst_tail got_nonzero=%0d exp=0", bad);
      end
      for (int a = 0; a < 1024; a++) ref_mem[a] = (a < p) ? 8'h55 : 8'h00;
      do_op(0, 16, 20, 8'h00, "midrst_next");
      read_check(20 * 16 + 2, ref_mem[20 * 16 + 2], "midrst_next_byte");
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      test_reset();
      test_fill();
      test_set_corners();
      test_clear_toggle();
      test_back_to_back();
      test_collision();
      test_random();
      test_reset_midfill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
